// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command codes, issue FSM encoding and image geometry
package lcd_pkg;
  localparam int IMG_PIXELS = 64;
  localparam logic [3:0] CMD_WRITE   = 4'd0;
  localparam logic [3:0] CMD_SHIFT_U = 4'd1;
  localparam logic [3:0] CMD_SHIFT_D = 4'd2;
  localparam logic [3:0] CMD_SHIFT_L = 4'd3;
  localparam logic [3:0] CMD_SHIFT_R = 4'd4;
  localparam logic [3:0] CMD_MAX     = 4'd5;
  localparam logic [3:0] CMD_MIN     = 4'd6;
  localparam logic [3:0] CMD_AVG     = 4'd7;
  typedef enum logic [1:0] {WAIT_RDY, ISSUE, GAP, DRAIN} lcd_state_e;
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: small command queue; a push alongside a pop is accepted even when full
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout_o  = mem[rd_q];
  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din_i;
  end
endmodule

// File: rtl/lcd_host_agent.sv
// lcd_host_agent: host-side image source, command issuer and frame capture for the LCD controller
module lcd_host_agent
  import lcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  input  logic [3:0]        hcmd,
  input  logic              hcmd_valid,
  output logic              hcmd_ready,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IROM_rd,
  input  logic [ADDR_W-1:0] IROM_A,
  output logic [DATA_W-1:0] IROM_Q,
  input  logic              IRAM_valid,
  input  logic [ADDR_W-1:0] IRAM_A,
  input  logic [DATA_W-1:0] IRAM_D,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              frame_done
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(2**ADDR_W);
  logic [DATA_W-1:0] image_mem [2**ADDR_W];
  logic [DATA_W-1:0] frame_mem [2**ADDR_W];
  lcd_state_e        state_q;
  logic [3:0]        cmd_q, q_head;
  logic              cmd_valid_q, ld_err_q, frame_done_q, frame_done_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              q_full, q_empty, push, pop;
  assign hcmd_ready   = !q_full && state_q != DRAIN;
  assign push         = hcmd_valid && hcmd_ready;
  assign pop          = state_q == WAIT_RDY && !q_empty && !busy;
  assign wr_count_d   = (IRAM_valid && wr_count_q != FULL_CNT) ? wr_count_q + 1'b1 : wr_count_q;
  assign frame_done_d = frame_done_q || done || wr_count_d == FULL_CNT;
  assign IROM_Q       = image_mem[IROM_A];
  assign rb_data      = frame_mem[rb_addr];
  assign cmd          = cmd_q;
  assign cmd_valid    = cmd_valid_q;
  assign ld_err       = ld_err_q;
  assign wr_count     = wr_count_q;
  assign frame_done   = frame_done_q;
  lcd_cmd_fifo #(.DEPTH(QDEPTH), .W(4)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (hcmd),
    .pop_i   (pop),
    .dout_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );
  // issue FSM: one-cycle strobe, then a dead cycle so the controller's busy can settle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_RDY;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_RDY: if (pop) begin
          state_q     <= ISSUE;
          cmd_q       <= q_head;
          cmd_valid_q <= 1'b1;
        end
        ISSUE: begin
          state_q     <= GAP;
          cmd_valid_q <= 1'b0;
        end
        GAP:     state_q <= (cmd_q == CMD_WRITE) ? DRAIN : WAIT_RDY;
        default: state_q <= DRAIN;
      endcase
    end
  end
  // load-conflict flag, capture counter and sticky completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_err_q     <= 1'b0;
      wr_count_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ld_err_q     <= ld_we && IROM_rd;
      wr_count_q   <= wr_count_d;
      frame_done_q <= frame_done_d;
    end
  end
  // image store: host writes lose to controller reads
  always_ff @(posedge clk) begin
    if (ld_we && !IROM_rd) image_mem[ld_addr] <= ld_data;
  end
  // frame store: every controller write lands, repeats overwrite
  always_ff @(posedge clk) begin
    if (IRAM_valid) frame_mem[IRAM_A] <= IRAM_D;
  end
endmodule

// File: tb/tb_lcd_host_agent.sv
// tb_lcd_host_agent: directed scenario tests for lcd_host_agent
module tb_lcd_host_agent;
  logic       clk = 1'b0, reset = 1'b1;
  logic       ld_we = 1'b0, ld_err;
  logic [5:0] ld_addr = '0, IROM_A = '0, IRAM_A = '0, rb_addr = '0;
  logic [7:0] ld_data = '0, IROM_Q, IRAM_D = '0, rb_data;
  logic [3:0] hcmd = '0, cmd;
  logic       hcmd_valid = 1'b0, hcmd_ready, cmd_valid;
  logic       busy = 1'b0, done = 1'b0, IROM_rd = 1'b0, IRAM_valid = 1'b0, frame_done;
  logic [6:0] wr_count;
  int checks = 0, errors = 0;

  lcd_host_agent dut (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_err(ld_err), .hcmd(hcmd), .hcmd_valid(hcmd_valid), .hcmd_ready(hcmd_ready),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done), .IROM_rd(IROM_rd),
    .IROM_A(IROM_A), .IROM_Q(IROM_Q), .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A),
    .IRAM_D(IRAM_D), .rb_addr(rb_addr), .rb_data(rb_data), .wr_count(wr_count),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL reset_cmd got %0d exp 0", cmd); end
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL reset_ld_err got %b exp 0", ld_err); end
    checks++; if (wr_count !== 7'd0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (hcmd_ready !== 1'b1) begin errors++; $display("FAIL reset_hcmd_ready got %b exp 1", hcmd_ready); end
  endtask

  task automatic test_image_load();
    for (int i = 0; i < 64; i++) begin
      ld_we = 1'b1; ld_addr = 6'(i); ld_data = 8'(i);
      tick();
    end
    ld_we = 1'b0;
    IROM_rd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      IROM_A = 6'(i);
      tick();
      checks++; if (IROM_Q !== 8'(i)) begin errors++; $display("FAIL irom_q addr %0d got %0d exp %0d", i, IROM_Q, i); end
      checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL irom_ld_err addr %0d got %b exp 0", i, ld_err); end
    end
    IROM_rd = 1'b0;
  endtask

  task automatic test_ld_conflict();
    IROM_rd = 1'b1; IROM_A = 6'd9;
    ld_we = 1'b1; ld_addr = 6'd5; ld_data = 8'hAA;
    tick();
    ld_we = 1'b0;
    checks++; if (ld_err !== 1'b1) begin errors++; $display("FAIL ld_err_pulse got %b exp 1", ld_err); end
    tick();
    checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL ld_err_clear got %b exp 0", ld_err); end
    IROM_A = 6'd5;
    #1;
    checks++; if (IROM_Q !== 8'd5) begin errors++; $display("FAIL ld_conflict_keep got %0d exp 5", IROM_Q); end
    IROM_rd = 1'b0;
  endtask

  task automatic test_fifo_order();
    int got[$];
    int at[$];
    logic [3:0] exp_cmd [4] = '{4'd3, 4'd4, 4'd5, 4'd6};
    busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      hcmd = 4'(k + 3); hcmd_valid = 1'b1;
      #1;
      checks++; if (hcmd_ready !== (k < 4)) begin errors++; $display("FAIL fifo_ready push %0d got %b exp %b", k, hcmd_ready, k < 4); end
      tick();
    end
    hcmd_valid = 1'b0;
    checks++; if (hcmd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %b exp 0", hcmd_ready); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL fifo_busy_hold got %b exp 0", cmd_valid); end
    busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (cmd_valid) begin got.push_back(int'(cmd)); at.push_back(c); end
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL fifo_issue_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] != int'(exp_cmd[i])) begin errors++; $display("FAIL fifo_order idx %0d got %0d exp %0d", i, got[i], exp_cmd[i]); end
      if (i > 0) begin
        checks++; if (at[i] - at[i-1] < 2) begin errors++; $display("FAIL fifo_spacing idx %0d got %0d exp >=2", i, at[i] - at[i-1]); end
      end
    end
    checks++; if (cmd !== 4'd6) begin errors++; $display("FAIL cmd_hold got %0d exp 6", cmd); end
    checks++; if (hcmd_ready !== 1'b1) begin errors++; $display("FAIL fifo_after_ready got %b exp 1", hcmd_ready); end
  endtask

  task automatic test_drain();
    int got[$];
    int at[$];
    logic [3:0] exp_cmd [3] = '{4'd1, 4'd2, 4'd0};
    busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hcmd = exp_cmd[k]; hcmd_valid = 1'b1;
      tick();
    end
    hcmd_valid = 1'b0;
    busy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (cmd_valid) begin got.push_back(int'(cmd)); at.push_back(c); end
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL drain_issue_count got %0d exp 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] != int'(exp_cmd[i])) begin errors++; $display("FAIL drain_order idx %0d got %0d exp %0d", i, got[i], exp_cmd[i]); end
      if (i > 0) begin
        checks++; if (at[i] - at[i-1] < 2) begin errors++; $display("FAIL drain_spacing idx %0d got %0d exp >=2", i, at[i] - at[i-1]); end
      end
    end
    checks++; if (hcmd_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %b exp 0", hcmd_ready); end
    hcmd = 4'd5; hcmd_valid = 1'b1;
    tick();
    hcmd_valid = 1'b0;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cmd_valid) got.push_back(int'(cmd));
    end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL drain_silent got %0d issues exp 0", got.size()); end
    checks++; if (hcmd_ready !== 1'b0) begin errors++; $display("FAIL drain_ready_stays got %b exp 0", hcmd_ready); end
  endtask

  task automatic test_capture();
    for (int i = 0; i < 64; i++) begin
      IRAM_valid = 1'b1; IRAM_A = 6'(i); IRAM_D = 8'(8'hFF - i);
      tick();
      if (i == 62) begin
        checks++; if (wr_count !== 7'd63) begin errors++; $display("FAIL cap_count63 got %0d exp 63", wr_count); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL cap_done_early got %b exp 0", frame_done); end
      end
    end
    IRAM_valid = 1'b0;
    checks++; if (wr_count !== 7'd64) begin errors++; $display("FAIL cap_count64 got %0d exp 64", wr_count); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL cap_frame_done got %b exp 1", frame_done); end
    for (int i = 0; i < 64; i++) begin
      rb_addr = 6'(i);
      #1;
      checks++; if (rb_data !== 8'(8'hFF - i)) begin errors++; $display("FAIL cap_rb addr %0d got %0h exp %0h", i, rb_data, 8'(8'hFF - i)); end
    end
    IRAM_valid = 1'b1; IRAM_A = 6'd0; IRAM_D = 8'h11;
    tick();
    IRAM_valid = 1'b0;
    rb_addr = 6'd0;
    #1;
    checks++; if (wr_count !== 7'd64) begin errors++; $display("FAIL cap_saturate got %0d exp 64", wr_count); end
    checks++; if (rb_data !== 8'h11) begin errors++; $display("FAIL cap_overwrite got %0h exp 11", rb_data); end
  endtask

  task automatic test_done();
    do_reset();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_clear got %b exp 0", frame_done); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL done_set got %b exp 1", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL done_sticky got %b exp 1", frame_done); end
  endtask

  task automatic test_reset_gap();
    bit seen = 1'b0;
    int extra = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      IRAM_valid = 1'b1; IRAM_A = 6'(i); IRAM_D = 8'h55;
      tick();
    end
    IRAM_valid = 1'b0;
    checks++; if (wr_count !== 7'd3) begin errors++; $display("FAIL rg_count got %0d exp 3", wr_count); end
    busy = 1'b1;
    hcmd_valid = 1'b1; hcmd = 4'd6; tick();
    hcmd = 4'd7; tick();
    hcmd_valid = 1'b0;
    busy = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = cmd_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rg_issue_timeout got none exp cmd_valid"); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rg_cmd_valid got %b exp 0", cmd_valid); end
    checks++; if (wr_count !== 7'd0) begin errors++; $display("FAIL rg_wr_count got %0d exp 0", wr_count); end
    checks++; if (hcmd_ready !== 1'b1) begin errors++; $display("FAIL rg_ready got %b exp 1", hcmd_ready); end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cmd_valid) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rg_queue_empty got %0d issues exp 0", extra); end
  endtask

  initial begin
    test_reset();
    test_image_load();
    test_ld_conflict();
    test_fifo_order();
    test_drain();
    test_capture();
    test_done();
    test_reset_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
